// File: rtl/sipo_deserializer.sv
// rtl/sipo_deserializer.sv - serial-in parallel-out word assembler with valid/ready output
// Collects sin_en-qualified bits into WIDTH-bit words; flags a sticky overrun on a dropped word.
module sipo_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sin,
  input  logic                     sin_en,
  input  logic                     sof,
  input  logic                     out_ready,
  input  logic                     clr_ovr,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     overrun
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_base;
  logic [WIDTH-1:0] shreg_next;
  logic             complete;
  logic             slot_free;

  // sof drops the partial word before the new bit shifts in
  always_comb begin
    shreg_base = sof ? '0 : shreg;
    if (MSB_FIRST) shreg_next = {shreg_base[WIDTH-2:0], sin};
    else           shreg_next = {sin, shreg_base[WIDTH-1:1]};
  end

  assign complete  = sin_en && !sof && (bit_cnt == LAST);
  assign slot_free = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (sin_en) begin
      shreg   <= shreg_next;
      bit_cnt <= (sof || complete) ? ((sof) ? CW'(1) : '0) : bit_cnt + 1'b1;
    end else if (sof) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (complete && slot_free) begin
        out_data  <= shreg_next;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      // set has priority over clear
      if (complete && !slot_free) overrun <= 1'b1;
      else if (clr_ovr)           overrun <= 1'b0;
    end
  end

endmodule
